// File: rtl/keypad_column_conditioner.sv
// Keypad column front-end: 2-flop synchronizer plus per-column hold filter.
// Presses pass straight through; a release waits for HOLD_CYCLES of continuous low.
module keypad_column_conditioner #(
    parameter int HOLD_CYCLES = 240000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] c_raw,
    output logic [3:0] c,
    output logic       any_active,
    output logic [3:0] released
);

    // HOLD_CYCLES=1 gives a zero-width counter, so keep at least one bit.
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RELEASING
    } state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    state_t        r_state [4];
    logic [CW-1:0] r_cnt [4];
    logic [3:0]    r_c;
    logic          r_anyActive;
    logic [3:0]    r_released;

    state_t        w_nextState [4];
    logic [CW-1:0] w_nextCnt [4];
    logic [3:0]    w_nextC;
    logic [3:0]    w_releaseNow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= c_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_nextC      = 4'b0000;
        w_releaseNow = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_nextState[i] = r_state[i];
            w_nextCnt[i]   = r_cnt[i];
            case (r_state[i])
                IDLE: begin
                    if (r_sync2[i]) begin
                        w_nextState[i] = HELD;
                    end
                end
                HELD: begin
                    if (!r_sync2[i]) begin
                        w_nextState[i] = RELEASING;
                        w_nextCnt[i]   = '0;
                    end
                end
                RELEASING: begin
                    if (r_sync2[i]) begin
                        w_nextState[i] = HELD;
                        w_nextCnt[i]   = '0;
                    end else if (r_cnt[i] == LAST_CNT) begin
                        w_nextState[i]  = IDLE;
                        w_releaseNow[i] = 1'b1;
                    end else begin
                        w_nextCnt[i] = r_cnt[i] + CW'(1);
                    end
                end
                default: begin
                    w_nextState[i] = IDLE;
                    w_nextCnt[i]   = '0;
                end
            endcase
            w_nextC[i] = (w_nextState[i] != IDLE);
        end
    end

    // Outputs are registered from next-state so c, any_active and released line up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= IDLE;
                r_cnt[i]   <= '0;
            end
            r_c         <= 4'b0000;
            r_anyActive <= 1'b0;
            r_released  <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= w_nextState[i];
                r_cnt[i]   <= w_nextCnt[i];
            end
            r_c         <= w_nextC;
            r_anyActive <= |w_nextC;
            r_released  <= w_releaseNow;
        end
    end

    assign c          = r_c;
    assign any_active = r_anyActive;
    assign released   = r_released;

endmodule

// File: tb/tb_keypad_column_conditioner.sv
// Scoreboard bench for keypad_column_conditioner with HOLD_CYCLES=4 and HOLD_CYCLES=1.
// Expected outputs come from a run-length model of the synchronized column samples.
module tb_keypad_column_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cRaw;
    logic [3:0] c4, rel4, c1, rel1;
    logic       any4, any1;

    always #5 clk = ~clk;

    keypad_column_conditioner #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .c_raw(cRaw),
        .c(c4), .any_active(any4), .released(rel4)
    );

    keypad_column_conditioner #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .c_raw(cRaw),
        .c(c1), .any_active(any1), .released(rel1)
    );

    int checkCount = 0;
    int failCount  = 0;
    int edgeNum    = 0;
    int startEdge;

    logic [8:0] sb4 [$];
    logic [8:0] sb1 [$];
    int         pulseEdge [$];
    logic [3:0] pulseVal [$];

    logic mS1   [2][4];
    logic mS2   [2][4];
    logic mEver [2][4];
    int   mLow  [2][4];
    int   holdOf [2] = '{4, 1};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // A column reads high while it has been seen high at least once and has not
    // yet accumulated more than HOLD consecutive low samples since then.
    task automatic modelEdge(input int m, input logic [3:0] raw, input logic rst, output logic [8:0] expOut);
        logic [3:0] cv;
        logic [3:0] rv;
        logic       seen;
        cv = 4'b0000;
        rv = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mS1[m][i]   = 1'b0;
                mS2[m][i]   = 1'b0;
                mEver[m][i] = 1'b0;
                mLow[m][i]  = 0;
            end else begin
                seen      = mS2[m][i];
                mS2[m][i] = mS1[m][i];
                mS1[m][i] = raw[i];
                if (seen) begin
                    mEver[m][i] = 1'b1;
                    mLow[m][i]  = 0;
                end else if (mLow[m][i] < holdOf[m] + 2) begin
                    mLow[m][i] = mLow[m][i] + 1;
                end
            end
            cv[i] = mEver[m][i] && (mLow[m][i] <= holdOf[m]);
            rv[i] = mEver[m][i] && (mLow[m][i] == holdOf[m] + 1);
        end
        expOut = {cv, |cv, rv};
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic rst);
        logic [8:0] e4;
        logic [8:0] e1;
        @(negedge clk);
        cRaw  = raw;
        reset = rst;
        modelEdge(0, raw, rst, e4);
        modelEdge(1, raw, rst, e1);
        sb4.push_back(e4);
        sb1.push_back(e1);
        @(posedge clk);
        #1;
        edgeNum++;
        if (sb4.size() == 0) checkOutput("sb4_empty", 32'd1, 32'd0);
        else checkOutput("sb_hold4", {c4, any4, rel4}, sb4.pop_front());
        if (sb1.size() == 0) checkOutput("sb1_empty", 32'd1, 32'd0);
        else checkOutput("sb_hold1", {c1, any1, rel1}, sb1.pop_front());
        if (rel4 != 4'b0000) begin
            pulseEdge.push_back(edgeNum);
            pulseVal.push_back(rel4);
        end
    endtask

    task automatic runCycles(input int n, input logic [3:0] raw);
        for (int k = 0; k < n; k++) applyStimulus(raw, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        cRaw  = 4'b0000;
        #1 reset = 1'b1;
        cRaw  = 4'b1111;
        #1;
        checkOutput("reset_hold4", {c4, any4, rel4}, 32'd0);
        checkOutput("reset_hold1", {c1, any1, rel1}, 32'd0);

        // Reset held with all columns high, then idle for 20 cycles.
        for (int k = 0; k < 3; k++) applyStimulus(4'b1111, 1'b1);
        runCycles(20, 4'b0000);
        checkOutput("idle_c", {c4, any4, rel4}, 32'd0);

        // Press/release latency on column 2.
        edgeNum = 0;
        runCycles(9, 4'b0000);
        runCycles(2, 4'b0100);
        checkOutput("press_pre", c4, 4'b0000);
        runCycles(1, 4'b0100);
        checkOutput("press_edge12", c4, 4'b0100);
        checkOutput("press_any", any4, 1'b1);
        runCycles(17, 4'b0100);
        runCycles(6, 4'b0000);
        checkOutput("release_pre36", {c4, rel4}, {4'b0100, 4'b0000});
        runCycles(1, 4'b0000);
        checkOutput("release_edge36", {c4, any4, rel4}, {4'b0000, 1'b0, 4'b0100});
        runCycles(1, 4'b0000);
        checkOutput("release_edge37", rel4, 4'b0000);

        // Bounce on column 1 while held, then a clean release.
        runCycles(5, 4'b0010);
        pulseEdge.delete();
        pulseVal.delete();
        for (int k = 0; k < 3; k++) begin
            runCycles(2, 4'b0000);
            checkOutput("bounce_low_held", c4[1], 1'b1);
            runCycles(2, 4'b0010);
            checkOutput("bounce_high_held", c4[1], 1'b1);
        end
        startEdge = edgeNum;
        runCycles(10, 4'b0000);
        checkOutput("bounce_pulse_count", pulseEdge.size(), 32'd1);
        if (pulseEdge.size() > 0) begin
            checkOutput("bounce_pulse_edge", pulseEdge[0], startEdge + 7);
            checkOutput("bounce_pulse_val", pulseVal[0], 4'b0010);
        end

        // Single-sample glitch produces a press that is held out.
        runCycles(1, 4'b0010);
        runCycles(12, 4'b0000);

        // Re-raise at cnt==3 returns to HELD; HOLD=1 instance releases right away.
        runCycles(5, 4'b0001);
        pulseEdge.delete();
        pulseVal.delete();
        runCycles(3, 4'b0000);
        checkOutput("h1_releasing_entered", c1[0], 1'b1);
        runCycles(1, 4'b0000);
        checkOutput("h1_release", {c1[0], rel1}, {1'b0, 4'b0001});
        runCycles(6, 4'b0001);
        checkOutput("boundary_held", c4[0], 1'b1);
        checkOutput("boundary_no_pulse", pulseEdge.size(), 32'd0);
        runCycles(10, 4'b0000);

        // Independent columns 0 and 3, releases five cycles apart.
        runCycles(5, 4'b1001);
        pulseEdge.delete();
        pulseVal.delete();
        runCycles(5, 4'b1000);
        runCycles(15, 4'b0000);
        checkOutput("indep_count", pulseEdge.size(), 32'd2);
        if (pulseEdge.size() >= 2) begin
            checkOutput("indep_first", pulseVal[0], 4'b0001);
            checkOutput("indep_second", pulseVal[1], 4'b1000);
            checkOutput("indep_gap", pulseEdge[1] - pulseEdge[0], 32'd5);
        end

        // Asynchronous reset while column 3 is releasing, key held through reset.
        runCycles(5, 4'b1000);
        runCycles(3, 4'b0000);
        checkOutput("async_pre_c3", c4[3], 1'b1);
        #2;
        cRaw  = 4'b1000;
        reset = 1'b1;
        #1;
        checkOutput("async_hold4", {c4, any4, rel4}, 32'd0);
        checkOutput("async_hold1", {c1, any1, rel1}, 32'd0);
        pulseEdge.delete();
        pulseVal.delete();
        applyStimulus(4'b1000, 1'b1);
        applyStimulus(4'b1000, 1'b1);
        runCycles(2, 4'b1000);
        checkOutput("async_redetect_pre", c4, 4'b0000);
        runCycles(1, 4'b1000);
        checkOutput("async_redetect", c4, 4'b1000);
        runCycles(5, 4'b1000);
        checkOutput("async_no_pulse", pulseEdge.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
